tbuf_bus_rx: RTL and testbench
==============================

Name: tbuf_bus_rx

Overview:
- Receiving end of a shared tristate data bus whose remote drivers are enable-gated tristate buffers.
- Samples the resolved bus value whenever a remote driver is enabled, and enforces a turnaround gap between driver bursts.
- Buffers captured words in a small first-word-fall-through FIFO and hands them to local logic with a valid/ready handshake.
- Flags overflow and contention (a driver enabled during turnaround).

Parameters:
- WIDTH, 8, bus and data word width in bits.
- DEPTH, 4, FIFO depth in words; must be a power of 2 and at least 2.
- TA_CYC, 1, number of idle turnaround cycles required after a burst ends; must be at least 1.

Ports:
- CP  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- BUS_D  input  WIDTH  resolved value of the shared tristate bus.
- BUS_E  input  1  OR of all remote driver enables; high means BUS_D is driven this cycle.
- BUS_RDY  output  1  advisory to remote drivers that a word would be accepted this cycle.
- Q  output  WIDTH  head-of-FIFO data.
- Q_VLD  output  1  Q holds a valid word.
- Q_RDY  input  1  local consumer accepts Q this cycle.
- CNT  output  log2(DEPTH)+1  current FIFO occupancy.
- OVF  output  1  sticky: a driven word was dropped because the FIFO was full.
- CONT  output  1  sticky: BUS_E was high during turnaround.

Behaviour:
Reset
- RST sampled high at an edge:
  - FSM goes to IDLE; FIFO is emptied (pointers 0).
  - CNT=0, Q_VLD=0, OVF=0, CONT=0, turnaround counter=0.
  - Q=0 (the storage array is not cleared).
- Reset mid-burst discards all buffered words. Words driven in the reset cycle are not captured.

FSM states: IDLE, RECV, TURN.
- IDLE:
  - BUS_E=1 -> attempt push of BUS_D, go to RECV.
  - BUS_E=0 -> stay.
- RECV:
  - BUS_E=1 -> attempt push, stay.
  - BUS_E=0 -> load the turnaround counter with TA_CYC-1, go to TURN.
- TURN:
  - No push.
  - BUS_E=1 sets CONT; the word is ignored.
  - Counter decrements each cycle; when the counter is 0 at an edge, go to IDLE.
  - TA_CYC=1 therefore gives exactly one TURN cycle.
- A burst ending and restarting with no gap yields a RECV -> TURN transition, and the restarted word triggers CONT.

Push, pop and flags
- Push succeeds if CNT<DEPTH, or if CNT==DEPTH and a pop occurs in the same cycle (Q_VLD & Q_RDY).
- Otherwise the word is dropped and OVF is set.
- OVF and CONT clear only on RST.
- Pop occurs when Q_VLD & Q_RDY.
- CNT increments on push only, decrements on pop only, and is unchanged when both occur.
- Q_VLD = (CNT != 0).
- Q is combinational from the read pointer (fall-through): a word pushed at edge k is visible on Q with Q_VLD=1 after edge k (latency 1 cycle from sampling).
- Read and write pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH. Order is strictly FIFO.
- Pop with CNT=0 is impossible because Q_VLD=0.

BUS_RDY
- BUS_RDY = (state != TURN) && (CNT < DEPTH).
- Combinational from registered state only; it does not depend on Q_RDY.

Other rules
- All outputs except Q, Q_VLD and BUS_RDY are registered.
- No X/Z detection: BUS_D is assumed resolved to 0/1 whenever BUS_E=1. A floating bus with BUS_E=0 is never sampled.

Test Plan:
1. Reset, then BUS_E=1 for 3 cycles with BUS_D=0x11,0x22,0x33, Q_RDY=0 -> CNT=3, Q=0x11 from the cycle after the first sample, OVF=0, then 1 TURN cycle with BUS_RDY=0.
2. With Q_RDY=1 and the same burst -> Q sequence 0x11,0x22,0x33 on consecutive cycles, CNT never exceeds 1, CNT=0 and Q_VLD=0 afterwards.
3. Q_RDY=0, burst of 6 words 0xA0..0xA5 with DEPTH=4 -> CNT=4, OVF=1 after the 5th word, BUS_RDY=0 while full; draining yields 0xA0..0xA3 only.
4. CNT=4 and Q_RDY=1 during a burst word 0xB0 -> pop and push in the same cycle, CNT stays 4, OVF stays 0, and 0xB0 is delivered last in order.
5. Burst ends, BUS_E=1 in the TURN cycle with 0xCC (TA_CYC=1) -> CONT=1, 0xCC not captured; with TA_CYC=3, TURN lasts 3 cycles before IDLE.
6. RST asserted mid-burst with CNT=2 and OVF=1 -> next cycle CNT=0, Q_VLD=0, OVF=0, CONT=0, state IDLE, BUS_RDY=1; the next driven word 0x5A is captured as the head.

Source files
------------

// File: rtl/tbuf_bus_rx.sv
// tbuf_bus_rx: receiver for a shared tristate bus driven by enable-gated
// remote buffers. Words are captured while any driver is enabled. A
// turnaround gap is enforced after each burst. Captured words pass through
// a small fall-through FIFO to a valid/ready consumer. Sticky flags report
// dropped words (OVF) and drivers enabled during turnaround (CONT).
module tbuf_bus_rx #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int TA_CYC = 1
) (
  input  logic                     CP,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         BUS_D,
  input  logic                     BUS_E,
  output logic                     BUS_RDY,
  output logic [WIDTH-1:0]         Q,
  output logic                     Q_VLD,
  input  logic                     Q_RDY,
  output logic [$clog2(DEPTH):0]   CNT,
  output logic                     OVF,
  output logic                     CONT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TA_CYC > 1) ? $clog2(TA_CYC) : 1;

  // Occupancy value meaning "completely full".
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  // Counter load value so that TURN lasts exactly TA_CYC cycles.
  localparam logic [TW-1:0] TA_LOAD_C = TW'(TA_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [TW-1:0]        ta_cnt_r;
  logic [TW-1:0]        ta_cnt_nxt_s;

  logic [WIDTH-1:0]     mem_r [DEPTH];
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [CW-1:0]        cnt_r;
  logic [CW-1:0]        cnt_nxt_s;
  logic                 ovf_r;
  logic                 cont_r;

  logic                 push_try_s;
  logic                 cont_set_s;
  logic                 full_s;
  logic                 pop_s;
  logic                 push_s;
  logic                 drop_s;
  logic                 wr_en_s;
  logic                 q_vld_s;

  // Bus FSM state and turnaround counter register.
  always_ff @(posedge CP) begin
    if (RST) begin
      state_r  <= ST_IDLE;
      ta_cnt_r <= {TW{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      ta_cnt_r <= ta_cnt_nxt_s;
    end
  end

  // Next-state logic: decides when a bus word is a push candidate and when
  // a driver is illegally active during turnaround.
  always_comb begin
    state_nxt_s  = state_r;
    ta_cnt_nxt_s = ta_cnt_r;
    push_try_s   = 1'b0;
    cont_set_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (BUS_E) begin
          push_try_s  = 1'b1;
          state_nxt_s = ST_RECV;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (BUS_E) begin
          push_try_s  = 1'b1;
          state_nxt_s = ST_RECV;
        end else begin
          ta_cnt_nxt_s = TA_LOAD_C;
          state_nxt_s  = ST_TURN;
        end
      end
      ST_TURN: begin
        // Any word seen here is ignored; only the flag records it.
        cont_set_s = BUS_E;
        if (ta_cnt_r == {TW{1'b0}}) begin
          state_nxt_s = ST_IDLE;
        end else begin
          ta_cnt_nxt_s = ta_cnt_r - TW'(1);
          state_nxt_s  = ST_TURN;
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        ta_cnt_nxt_s = {TW{1'b0}};
      end
    endcase
  end

  // FIFO handshake decode: a full FIFO still accepts a word when the head
  // leaves in the same cycle.
  always_comb begin
    q_vld_s = (cnt_r != {CW{1'b0}});
    full_s  = (cnt_r == DEPTH_C);
    pop_s   = q_vld_s && Q_RDY;
    push_s  = push_try_s && (!full_s || pop_s);
    drop_s  = push_try_s && full_s && !pop_s;
    wr_en_s = push_s && !RST;
    case ({push_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + CW'(1);
      2'b01:   cnt_nxt_s = cnt_r - CW'(1);
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // FIFO storage write; contents are never cleared, pointers define validity.
  always_ff @(posedge CP) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= BUS_D;
    end
  end

  // FIFO pointers, occupancy and sticky error flags.
  always_ff @(posedge CP) begin
    if (RST) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      ovf_r    <= 1'b0;
      cont_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      cnt_r <= cnt_nxt_s;
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
      if (cont_set_s) begin
        cont_r <= 1'b1;
      end
    end
  end

  // Output drive: head word falls through; Q reads 0 whenever the FIFO is
  // empty so stale storage never shows after reset.
  always_comb begin
    Q_VLD   = q_vld_s;
    Q       = q_vld_s ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
    BUS_RDY = (state_r != ST_TURN) && (cnt_r < DEPTH_C);
    CNT     = cnt_r;
    OVF     = ovf_r;
    CONT    = cont_r;
  end

endmodule

// File: tb/tb_tbuf_bus_rx.sv
// Testbench for tbuf_bus_rx: two instances (TA_CYC=1 and TA_CYC=3) share
// stimulus; each is compared every cycle with a queue-level behavioural model.
module tb_tbuf_bus_rx;

  logic       clk;
  logic       rst;
  logic [7:0] bus_d;
  logic       bus_e;
  logic       q_rdy;

  logic       rdy_w  [2];
  logic [7:0] q_w    [2];
  logic       qv_w   [2];
  logic [2:0] cnt_w  [2];
  logic       ovf_w  [2];
  logic       cont_w [2];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model: a word list with head/tail indices plus flags.
  logic [7:0] m_buf   [2][16];
  int         m_head  [2];
  int         m_cnt   [2];
  bit         m_ovf   [2];
  bit         m_cont  [2];
  bit         m_burst [2];
  int         m_turn  [2];
  int         m_ta    [2];

  tbuf_bus_rx #(.WIDTH(8), .DEPTH(4), .TA_CYC(1)) u_dut0 (
    .CP(clk), .RST(rst), .BUS_D(bus_d), .BUS_E(bus_e), .BUS_RDY(rdy_w[0]),
    .Q(q_w[0]), .Q_VLD(qv_w[0]), .Q_RDY(q_rdy), .CNT(cnt_w[0]),
    .OVF(ovf_w[0]), .CONT(cont_w[0])
  );

  tbuf_bus_rx #(.WIDTH(8), .DEPTH(4), .TA_CYC(3)) u_dut1 (
    .CP(clk), .RST(rst), .BUS_D(bus_d), .BUS_E(bus_e), .BUS_RDY(rdy_w[1]),
    .Q(q_w[1]), .Q_VLD(qv_w[1]), .Q_RDY(q_rdy), .CNT(cnt_w[1]),
    .OVF(ovf_w[1]), .CONT(cont_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock edge of the model: burst/turnaround bookkeeping and FIFO queue.
  task automatic model_step(input int m, input bit r, input bit e,
                            input logic [7:0] d, input bit qr);
    bit pop;
    bit push;
    if (r) begin
      m_head[m] = 0; m_cnt[m] = 0; m_ovf[m] = 1'b0; m_cont[m] = 1'b0;
      m_burst[m] = 1'b0; m_turn[m] = 0;
    end else begin
      pop  = (m_cnt[m] > 0) && qr;
      push = 1'b0;
      if (m_turn[m] > 0) begin
        if (e) m_cont[m] = 1'b1;
        m_turn[m]--;
      end else if (e) begin
        m_burst[m] = 1'b1;
        if (m_cnt[m] < 4 || pop) push = 1'b1;
        else m_ovf[m] = 1'b1;
      end else if (m_burst[m]) begin
        m_burst[m] = 1'b0;
        m_turn[m]  = m_ta[m];
      end
      if (pop) begin
        m_head[m]++;
        m_cnt[m]--;
      end
      if (push) begin
        m_buf[m][(m_head[m] + m_cnt[m]) % 16] = d;
        m_cnt[m]++;
      end
    end
  endtask

  task automatic tick(input bit r, input bit e, input logic [7:0] d, input bit qr);
    rst = r; bus_e = e; bus_d = d; q_rdy = qr;
    @(posedge clk);
    for (int m = 0; m < 2; m++) model_step(m, r, e, d, qr);
    @(negedge clk);
    #1;
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        logic [7:0] exp_q;
        exp_q = (m_cnt[m] != 0) ? m_buf[m][m_head[m] % 16] : 8'h00;
        chk($sformatf("dut%0d_q", m),    q_w[m],    exp_q);
        chk($sformatf("dut%0d_qvld", m), qv_w[m],   (m_cnt[m] != 0));
        chk($sformatf("dut%0d_cnt", m),  cnt_w[m],  m_cnt[m]);
        chk($sformatf("dut%0d_ovf", m),  ovf_w[m],  m_ovf[m]);
        chk($sformatf("dut%0d_cont", m), cont_w[m], m_cont[m]);
        chk($sformatf("dut%0d_busrdy", m), rdy_w[m],
            (m_turn[m] == 0) && (m_cnt[m] < 4));
      end
    end
  end

  initial begin
    m_ta[0] = 1;
    m_ta[1] = 3;
    rst = 1'b1; bus_e = 1'b0; bus_d = 8'h00; q_rdy = 1'b0;
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk_en = 1'b1;
    chk("reset_cnt", cnt_w[0], 0);
    chk("reset_qvld", qv_w[0], 0);
    chk("reset_busrdy", rdy_w[0], 1);

    // 1: three-word burst, no consumer, then turnaround lengths.
    tick(1'b0, 1'b1, 8'h11, 1'b0);
    chk("t1_q_first", q_w[0], 8'h11);
    tick(1'b0, 1'b1, 8'h22, 1'b0);
    tick(1'b0, 1'b1, 8'h33, 1'b0);
    chk("t1_cnt", cnt_w[0], 3);
    chk("t1_pin_model_cnt", m_cnt[0], 3);
    chk("t1_q_head", q_w[0], 8'h11);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t1_turn_rdy0", rdy_w[0], 0);
    chk("t5_turn1_rdy1", rdy_w[1], 0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t1_idle_rdy0", rdy_w[0], 1);
    chk("t5_turn2_rdy1", rdy_w[1], 0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t5_turn3_rdy1", rdy_w[1], 0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t5_idle_rdy1", rdy_w[1], 1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00, 1'b1);

    // 2: same burst with an always-ready consumer.
    tick(1'b0, 1'b1, 8'h11, 1'b1);
    chk("t2_q0", q_w[0], 8'h11);
    tick(1'b0, 1'b1, 8'h22, 1'b1);
    chk("t2_q1", q_w[0], 8'h22);
    chk("t2_cnt1", cnt_w[0], 1);
    tick(1'b0, 1'b1, 8'h33, 1'b1);
    chk("t2_q2", q_w[0], 8'h33);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t2_empty", qv_w[0], 0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 8'h00, 1'b1);

    // 3: overflow with a six-word burst.
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
    chk("t3_full_cnt", cnt_w[0], 4);
    chk("t3_full_rdy", rdy_w[0], 0);
    chk("t3_ovf_before", ovf_w[0], 0);
    tick(1'b0, 1'b1, 8'hA4, 1'b0);
    chk("t3_ovf_after", ovf_w[0], 1);
    tick(1'b0, 1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_drain%0d", i), q_w[0], 8'hA0 + 8'(i));
      tick(1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk("t3_drained", qv_w[0], 0);

    // 4: simultaneous push and pop while full.
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 8'hC0 + 8'(i), 1'b0);
    tick(1'b0, 1'b1, 8'hB0, 1'b1);
    chk("t4_cnt", cnt_w[0], 4);
    chk("t4_ovf", ovf_w[0], 0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    chk("t4_d0", q_w[0], 8'hC1);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t4_d1", q_w[0], 8'hC2);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t4_d2", q_w[0], 8'hC3);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t4_last", q_w[0], 8'hB0);
    tick(1'b0, 1'b0, 8'h00, 1'b1);

    // 5: driver enabled during turnaround.
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b1, 8'h01, 1'b0);
    tick(1'b0, 1'b1, 8'h02, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b1, 8'hCC, 1'b0);
    chk("t5_cont0", cont_w[0], 1);
    chk("t5_cont1", cont_w[1], 1);
    chk("t5_cnt_nocap", cnt_w[0], 2);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 8'h00, 1'b1);

    // 6: reset mid-burst with buffered words and OVF set.
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 8'h60 + 8'(i), 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00, 1'b1);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b1, 8'h99, 1'b0);
    chk("t6_pre_cnt", cnt_w[0], 2);
    chk("t6_pre_ovf", ovf_w[0], 1);
    tick(1'b1, 1'b1, 8'h77, 1'b0);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("t6_cnt%0d", m),  cnt_w[m],  0);
      chk($sformatf("t6_qvld%0d", m), qv_w[m],   0);
      chk($sformatf("t6_ovf%0d", m),  ovf_w[m],  0);
      chk($sformatf("t6_cont%0d", m), cont_w[m], 0);
      chk($sformatf("t6_rdy%0d", m),  rdy_w[m],  1);
    end
    tick(1'b0, 1'b1, 8'h5A, 1'b0);
    chk("t6_head", q_w[0], 8'h5A);
    tick(1'b0, 1'b0, 8'h00, 1'b1);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 99) < 60),
           8'($urandom),
           ($urandom_range(0, 99) < 45));
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
